// File: rtl/ysyx_24100006_axi_pkg.sv
// Shared definitions for the AXI SRAM slave: FSM state encodings,
// AXI response codes and the burst address increment helper.
package ysyx_24100006_axi_pkg;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // INCR burst: the next beat address advances by the beat size in bytes.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size);
        return addr + (32'd1 << size);
    endfunction

endpackage

// File: rtl/ysyx_24100006_lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5.
// Advances every clock; used as the source of random handshake delays
// when AXI_SRAM_DELAY_EN is defined.
module ysyx_24100006_lfsr8 (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] value
);

    logic feedback;

    assign feedback = value[7] ^ value[5] ^ value[4] ^ value[3];

    // Shift register steps unconditionally once out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= 8'hA5;
        end else begin
            value <= {value[6:0], feedback};
        end
    end

endmodule

// File: rtl/ysyx_24100006_axi_sram.sv
// AXI4 single-port-memory slave with independent read and write channels.
// Optional build macro: AXI_SRAM_DELAY_EN inserts pseudo-random 0..7 cycle
// stalls before every handshake the slave offers; undefined means none.
//
// Read FSM
//   state  | meaning
//   R_IDLE | arready offered, waiting for a read burst
//   R_DATA | presenting read beats until the rlast beat is accepted
// Write FSM
//   state  | meaning
//   W_IDLE | awready offered, waiting for a write burst
//   W_DATA | wready offered, accepting write beats
//   W_RESP | bvalid offered, waiting for bready
module ysyx_24100006_axi_sram
    import ysyx_24100006_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [31:0] axi_araddr,
    input  logic [7:0]  axi_arlen,
    input  logic [2:0]  axi_arsize,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic [1:0]  axi_rresp,
    output logic [31:0] axi_rdata,
    output logic        axi_rlast,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_awaddr,
    input  logic [7:0]  axi_awlen,
    input  logic [2:0]  axi_awsize,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wlast,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    output logic [1:0]  axi_bresp
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    // Unsigned offset compare also rejects addresses below BASE_ADDR (wraps high).
    function automatic logic in_range(input logic [31:0] addr);
        return (addr - BASE_ADDR) < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    logic [2:0] dly;

`ifdef AXI_SRAM_DELAY_EN
    logic [7:0] lfsr_value;

    ysyx_24100006_lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (lfsr_value)
    );

    assign dly = lfsr_value[2:0];
`else
    assign dly = 3'd0;
`endif

    // ---------------------------------------------------------------- read
    r_state_t    r_state;
    r_state_t    r_state_next;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [2:0]  r_size;
    logic [7:0]  r_cnt;
    logic [2:0]  ar_wait;
    logic [2:0]  r_wait;
    logic        rvalid_q;
    logic        rlast_q;
    logic [1:0]  rresp_q;
    logic [31:0] rdata_q;

    logic        ar_hs;
    logic        r_hs;
    logic        r_advance;
    logic        r_load;
    logic [31:0] r_ld_addr;
    logic [7:0]  r_ld_cnt;
    logic [7:0]  r_ld_len;

    assign axi_arready = (r_state == R_IDLE) && (ar_wait == 3'd0);
    assign axi_rvalid  = rvalid_q;
    assign axi_rlast   = rvalid_q & rlast_q;
    assign axi_rresp   = rresp_q;
    assign axi_rdata   = rdata_q;

    assign ar_hs     = axi_arvalid && axi_arready;
    assign r_hs      = rvalid_q && axi_rready;
    assign r_advance = r_hs && !rlast_q;

    // Read state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_next;
        end
    end

    // Read next-state: a burst ends when its rlast beat is accepted.
    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_next = R_DATA;
            R_DATA:  if (r_hs && rlast_q) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Pick which beat gets fetched into the output register this cycle.
    // Fetching at the handshake edge means a concurrent write to the same
    // word lands after the read, so the reader sees pre-write data.
    always_comb begin
        r_load    = 1'b0;
        r_ld_addr = r_addr;
        r_ld_cnt  = r_cnt;
        r_ld_len  = r_len;
        if (ar_hs) begin
            r_load    = (dly == 3'd0);
            r_ld_addr = axi_araddr;
            r_ld_cnt  = 8'd0;
            r_ld_len  = axi_arlen;
        end else if (r_state == R_DATA) begin
            if (r_advance) begin
                r_load    = (dly == 3'd0);
                r_ld_addr = next_addr(r_addr, r_size);
                r_ld_cnt  = r_cnt + 8'd1;
            end else if (!rvalid_q && (r_wait == 3'd0)) begin
                r_load = 1'b1;
            end
        end
    end

    // Read burst tracking, output beat register and delay counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr   <= 32'd0;
            r_len    <= 8'd0;
            r_size   <= 3'd0;
            r_cnt    <= 8'd0;
            ar_wait  <= 3'd0;
            r_wait   <= 3'd0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= 32'd0;
        end else begin
            if (ar_hs) begin
                r_addr <= axi_araddr;
                r_len  <= axi_arlen;
                r_size <= axi_arsize;
                r_cnt  <= 8'd0;
            end else if (r_advance) begin
                r_addr <= r_ld_addr;
                r_cnt  <= r_ld_cnt;
            end

            if (r_load) begin
                rvalid_q <= 1'b1;
                rlast_q  <= (r_ld_cnt == r_ld_len);
                rresp_q  <= in_range(r_ld_addr) ? RESP_OKAY : RESP_DECERR;
                rdata_q  <= in_range(r_ld_addr) ? mem[word_idx(r_ld_addr)] : 32'd0;
            end else if (r_hs) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end

            // The fetch cycle itself counts as one cycle of the beat delay.
            if ((ar_hs || r_advance) && (dly != 3'd0)) begin
                r_wait <= dly - 3'd1;
            end else if ((r_state == R_DATA) && !rvalid_q && (r_wait != 3'd0)) begin
                r_wait <= r_wait - 3'd1;
            end

            if (r_hs && rlast_q) begin
                ar_wait <= dly;
            end else if ((r_state == R_IDLE) && (ar_wait != 3'd0)) begin
                ar_wait <= ar_wait - 3'd1;
            end
        end
    end

    // --------------------------------------------------------------- write
    w_state_t    w_state;
    w_state_t    w_state_next;
    logic [31:0] w_addr;
    logic [7:0]  w_len;
    logic [2:0]  w_size;
    logic [7:0]  w_cnt;
    logic        w_dec;
    logic [2:0]  aw_wait;
    logic [2:0]  w_wait;
    logic [2:0]  b_wait;
    logic [1:0]  bresp_q;

    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;
    logic        w_cnt_hit;
    logic        w_last_beat;
    logic        w_beat_ok;

    assign axi_awready = (w_state == W_IDLE) && (aw_wait == 3'd0);
    assign axi_wready  = (w_state == W_DATA) && (w_wait == 3'd0);
    assign axi_bvalid  = (w_state == W_RESP) && (b_wait == 3'd0);
    assign axi_bresp   = bresp_q;

    assign aw_hs       = axi_awvalid && axi_awready;
    assign w_hs        = axi_wvalid && axi_wready;
    assign b_hs        = axi_bvalid && axi_bready;
    assign w_cnt_hit   = (w_cnt == w_len);
    assign w_last_beat = axi_wlast || w_cnt_hit;
    assign w_beat_ok   = in_range(w_addr);

    // Write state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_next;
        end
    end

    // Write next-state: data phase ends on wlast or the awlen-th beat, whichever first.
    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_next = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_state_next = W_RESP;
            W_RESP:  if (b_hs) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    // Write burst tracking, response code and delay counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_addr  <= 32'd0;
            w_len   <= 8'd0;
            w_size  <= 3'd0;
            w_cnt   <= 8'd0;
            w_dec   <= 1'b0;
            aw_wait <= 3'd0;
            w_wait  <= 3'd0;
            b_wait  <= 3'd0;
            bresp_q <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                w_addr <= axi_awaddr;
                w_len  <= axi_awlen;
                w_size <= axi_awsize;
                w_cnt  <= 8'd0;
                w_dec  <= 1'b0;
            end else if (w_hs && !w_last_beat) begin
                w_addr <= next_addr(w_addr, w_size);
                w_cnt  <= w_cnt + 8'd1;
                if (!w_beat_ok) w_dec <= 1'b1;
            end

            // Decode error outranks a wlast/awlen disagreement.
            if (w_hs && w_last_beat) begin
                if (w_dec || !w_beat_ok) begin
                    bresp_q <= RESP_DECERR;
                end else if (axi_wlast != w_cnt_hit) begin
                    bresp_q <= RESP_SLVERR;
                end else begin
                    bresp_q <= RESP_OKAY;
                end
            end

            if (aw_hs || (w_hs && !w_last_beat)) begin
                w_wait <= dly;
            end else if ((w_state == W_DATA) && (w_wait != 3'd0)) begin
                w_wait <= w_wait - 3'd1;
            end

            if (w_hs && w_last_beat) begin
                b_wait <= dly;
            end else if ((w_state == W_RESP) && (b_wait != 3'd0)) begin
                b_wait <= b_wait - 3'd1;
            end

            if (b_hs) begin
                aw_wait <= dly;
            end else if ((w_state == W_IDLE) && (aw_wait != 3'd0)) begin
                aw_wait <= aw_wait - 3'd1;
            end
        end
    end

    // Storage array: byte-lane writes, out-of-range beats dropped; not reset.
    always_ff @(posedge clk) begin
        if (w_hs && w_beat_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (axi_wstrb[b]) begin
                    mem[word_idx(w_addr)][8*b +: 8] <= axi_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
